// File: rtl/d_mem_responder.sv
// ---------------------------------------------------------------------------
// d_mem_responder
//
// Purpose:
//   A multi-cycle data memory that sits behind the MIPS core's load/store
//   port. It accepts one word load or store per valid/ready handshake. It
//   inserts WAIT_CYCLES wait states, performs the array access, and then
//   returns exactly one single-cycle response strobe that carries the load
//   data and the error status.
//
// Parameters:
//   DEPTH        memory size in 32-bit words (power of two, >= 4)
//   WAIT_CYCLES  wait states between acceptance and the access (0..15)
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   req_valid  in   request present
//   req_ready  out  request can be accepted (IDLE and reset low); combinational
//   req_write  in   1 = store word, 0 = load word
//   req_addr   in   byte address; word index = req_addr[log2(DEPTH)+1:2]
//   req_wdata  in   store data
//   rsp_valid  out  one-cycle response strobe (registered)
//   rsp_rdata  out  load data, 0 for stores and errors (registered)
//   rsp_error  out  misaligned-access flag, valid with rsp_valid (registered)
//
// Optional feature:
//   DMEM_MISALIGN_TRAP_EN  when defined, a request with req_addr[1:0] != 0
//                          does not access the array. It answers with
//                          rsp_error = 1 and rsp_rdata = 0 after the normal
//                          latency. When it is undefined, the low address
//                          bits are ignored and rsp_error is always 0.
// ---------------------------------------------------------------------------
module d_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
  localparam bit         NO_WAIT   = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // Control state
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Registered response
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_error_q, rsp_error_d;

  // Request latched at the accept edge. This is data only, so it has no reset.
  logic          write_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;

  // Storage. It starts at zero at power-up and is never cleared by reset.
  logic [31:0] mem_q [DEPTH] = '{default: 32'h0};

  // Access datapath
  logic          accept;
  logic          do_access;
  logic          acc_write;
  logic [AW+1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic [AW-1:0] acc_idx;
  logic          misaligned;
  logic          mem_we;
  logic [31:0]   rd_word;

  // Upper address bits alias away, and without the trap the byte offset
  // is irrelevant. They are folded here only so that they are consumed.
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:AW+2], acc_addr[1:0]};

  // Ready depends on reset, so nothing is accepted while reset is held.
  assign req_ready = (state_q == S_IDLE) && !reset;
  assign accept    = req_valid && req_ready;

  // With zero wait states the access happens at the accept edge, so it
  // must use the live request inputs. Otherwise it uses the latched copy.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == S_IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr[AW+1:0];
      acc_wdata = req_wdata;
    end
  end

  // The access edge is either the accept edge (no wait states) or the last
  // WAIT cycle. A counter value of 0 in WAIT cannot occur. It is folded
  // into the last-cycle case so that WAIT can never stall.
  assign do_access = ((state_q == S_IDLE) && accept && NO_WAIT) ||
                     ((state_q == S_WAIT) && (cnt_q <= 4'd1));

  assign acc_idx = acc_addr[AW+1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misaligned = |acc_addr[1:0];
`else
  assign misaligned = 1'b0;
`endif

  assign mem_we  = do_access && acc_write && !misaligned;
  assign rd_word = mem_q[acc_idx];

  // -------------------------------------------------------------------------
  // State register (control and response flops, async reset)
  // -------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (NO_WAIT) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q > 4'd1) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          cnt_d   = 4'd0;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: the response is loaded on the access edge. Every other
  // edge clears it, which gives a one-cycle strobe in RESP and zeros
  // elsewhere.
  // -------------------------------------------------------------------------
  always_comb begin
    rsp_valid_d = do_access;
    rsp_error_d = do_access && misaligned;
    rsp_rdata_d = 32'h0;
    if (do_access && !acc_write && !misaligned) begin
      rsp_rdata_d = rd_word;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_error = rsp_error_q;

  // -------------------------------------------------------------------------
  // Request capture at the accept edge
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr[AW+1:0];
      wdata_q <= req_wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Array write. A store still pending in WAIT when reset hits never reaches
  // here, because reset forces the FSM back to IDLE first.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

endmodule

// File: tb/tb_d_mem_responder.sv
// Directed bench for d_mem_responder. Instance A uses WAIT_CYCLES = 2 and
// instance B uses WAIT_CYCLES = 0. Both share the clock and the reset.
module tb_d_mem_responder;

  logic clk = 1'b0;
  logic rst;

  logic        a_valid, a_ready, a_write, a_rvalid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_ready, b_write, b_rvalid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  d_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) dut_a (
    .clock(clk), .reset(rst),
    .req_valid(a_valid), .req_ready(a_ready), .req_write(a_write),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .rsp_valid(a_rvalid), .rsp_rdata(a_rdata), .rsp_error(a_err)
  );

  d_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut_b (
    .clock(clk), .reset(rst),
    .req_valid(b_valid), .req_ready(b_ready), .req_write(b_write),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .rsp_valid(b_rvalid), .rsp_rdata(b_rdata), .rsp_error(b_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic wr,
                       input logic [31:0] ad, input logic [31:0] wd);
    if (sel == 0) begin
      a_valid = v; a_write = wr; a_addr = ad; a_wdata = wd;
    end else begin
      b_valid = v; b_write = wr; b_addr = ad; b_wdata = wd;
    end
  endtask

  function automatic logic rv(input int sel);
    return (sel == 0) ? a_rvalid : b_rvalid;
  endfunction
  function automatic logic rr(input int sel);
    return (sel == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic re(input int sel);
    return (sel == 0) ? a_err : b_err;
  endfunction
  function automatic logic [31:0] rd(input int sel);
    return (sel == 0) ? a_rdata : b_rdata;
  endfunction

  // Single transaction with the fixed expected timeline: accept edge k,
  // strobe after edge k+W, ready again after edge k+W+1.
  task automatic txn(input int sel, input logic wr, input logic [31:0] ad,
                     input logic [31:0] wd, input logic [31:0] exp_rd,
                     input logic exp_er);
    int w;
    w = (sel == 0) ? 2 : 0;
    chk("ready_before_req", 32'(rr(sel)), 32'd1);
    drive(sel, 1'b1, wr, ad, wd);
    tick();
    drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < w; i++) begin
      chk("no_rsp_in_wait", 32'(rv(sel)), 32'd0);
      chk("busy_in_wait", 32'(rr(sel)), 32'd0);
      tick();
    end
    chk("rsp_valid", 32'(rv(sel)), 32'd1);
    chk("rsp_rdata", rd(sel), exp_rd);
    chk("rsp_error", 32'(re(sel)), 32'(exp_er));
    chk("busy_in_resp", 32'(rr(sel)), 32'd0);
    tick();
    chk("rsp_strobe_ends", 32'(rv(sel)), 32'd0);
    chk("rdata_idle_zero", rd(sel), 32'h0);
    chk("ready_after_resp", 32'(rr(sel)), 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    chk("reset_rsp_valid", 32'(a_rvalid), 32'd0);
    chk("reset_rdata", a_rdata, 32'h0);
    chk("reset_error", 32'(a_err), 32'd0);
    chk("reset_ready_a", 32'(a_ready), 32'd0);
    chk("reset_ready_b", 32'(b_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("ready_after_reset_a", 32'(a_ready), 32'd1);
    chk("ready_after_reset_b", 32'(b_ready), 32'd1);

    // Write then read with two wait states
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);

    // Zero wait states: preload, then back-to-back reads with valid held high
    txn(1, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'h0, 1'b0);
    txn(1, 1'b1, 32'h0000_0004, 32'h2222_2222, 32'h0, 1'b0);
    drive(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    tick();
    chk("b2b_rsp0_valid", 32'(b_rvalid), 32'd1);
    chk("b2b_rsp0_rdata", b_rdata, 32'h1111_1111);
    chk("b2b_rsp0_busy", 32'(b_ready), 32'd0);
    drive(1, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    tick();
    chk("b2b_gap_valid", 32'(b_rvalid), 32'd0);
    chk("b2b_gap_ready", 32'(b_ready), 32'd1);
    tick();
    chk("b2b_rsp1_valid", 32'(b_rvalid), 32'd1);
    chk("b2b_rsp1_rdata", b_rdata, 32'h2222_2222);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("b2b_end_valid", 32'(b_rvalid), 32'd0);
    chk("b2b_end_ready", 32'(b_ready), 32'd1);

    // Busy: a store pulsed during WAIT is ignored
    txn(0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 1'b0);
    drive(0, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    tick();
    drive(0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234);
    tick();
    chk("busy_ready_low", 32'(a_ready), 32'd0);
    chk("busy_no_rsp", 32'(a_rvalid), 32'd0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    chk("busy_rsp_valid", 32'(a_rvalid), 32'd1);
    chk("busy_rsp_rdata", a_rdata, 32'h0);
    tick();
    chk("busy_ready_back", 32'(a_ready), 32'd1);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b0);

    // Aliasing modulo 1 KiB
    txn(0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h0000_0004, 32'h0, 32'hA5A5_A5A5, 1'b0);

    // Reset during WAIT discards the pending store
    drive(0, 1'b1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_wait_valid", 32'(a_rvalid), 32'd0);
    chk("rst_wait_rdata", a_rdata, 32'h0);
    chk("rst_wait_error", 32'(a_err), 32'd0);
    chk("rst_wait_ready", 32'(a_ready), 32'd0);
    tick();
    chk("rst_hold_valid", 32'(a_rvalid), 32'd0);
    chk("rst_hold_ready", 32'(a_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_ready", 32'(a_ready), 32'd1);
    txn(0, 1'b0, 32'h0000_0008, 32'h0, 32'h0, 1'b0);

    // Reset during RESP clears the registered response at once
    drive(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    tick();
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    chk("pre_rst_resp_valid", 32'(a_rvalid), 32'd1);
    chk("pre_rst_resp_rdata", a_rdata, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1;
    chk("rst_resp_valid", 32'(a_rvalid), 32'd0);
    chk("rst_resp_rdata", a_rdata, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_resp_ready", 32'(a_ready), 32'd1);

    // Misaligned store to 0x13 (word index 4, which holds 0xDEADBEEF)
`ifdef DMEM_MISALIGN_TRAP_EN
    txn(0, 1'b1, 32'h0000_0013, 32'h5555_5555, 32'h0, 1'b1);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0);
`else
    txn(0, 1'b1, 32'h0000_0013, 32'h5555_5555, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'h5555_5555, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/d_mem_responder.md
# d_mem_responder

Multi-cycle data-memory responder on the far side of the MIPS core's load/store port. It accepts one word read or write per request through a valid/ready handshake and inserts a configurable number of wait states. It returns exactly one response pulse carrying read data and status. It replaces the combinational data memory when the core runs in multi-cycle or stalled mode, and lets the load/store path be exercised against realistic memory latency.

## Interface
- DEPTH, 256: memory size in 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 2: wait states between request acceptance and the memory access; range 0..15.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request; high only in IDLE while reset is low.
- req_write  in  1  1 = store word (sw), 0 = load word (lw).
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (register rt).
- rsp_valid  out  1  one-cycle response strobe.
- rsp_rdata  out  32  load data; 0 for writes and errors.
- rsp_error  out  1  misaligned-access flag, valid with rsp_valid.

## Operation
- Storage: DEPTH × 32 array, zero-initialised at time 0. Reset does not clear the array.
- Word index: req_addr[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses alias modulo 4·DEPTH bytes.
- Accept: handshake when req_valid && req_ready on a rising edge. At that edge, write, addr and wdata are latched. req_valid is ignored while req_ready = 0; there is no queueing.
- FSM states: IDLE, WAIT, RESP.
  - IDLE → WAIT on accept with WAIT_CYCLES ≥ 1; the counter loads WAIT_CYCLES.
  - IDLE → RESP on accept with WAIT_CYCLES = 0; the access is performed at the accept edge, using the request inputs directly.
  - WAIT, counter > 1: decrement and stay in WAIT.
  - WAIT, counter = 1: perform the access using the latched request, then go to RESP.
  - RESP → IDLE unconditionally after one cycle.
- Access:
  - Write: mem[idx] ← wdata; rsp_rdata = 0.
  - Read: rsp_rdata ← mem[idx].
- Outputs are registered. rsp_valid = 1 only in RESP. rsp_rdata and rsp_error hold their values during RESP and return to 0 in IDLE.
- Reset (asynchronous, any state): state → IDLE, counter → 0, rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, req_ready = 0 while reset is high.
  - A write that has not yet been performed is discarded.
  - A write already performed stays in memory.

## Timing
- Request accepted at edge k: the access occurs at edge k+WAIT_CYCLES, and rsp_valid is high for the single cycle following that edge.
- req_ready is low from edge k until edge k+WAIT_CYCLES+1, when the FSM re-enters IDLE. The earliest next accept is at edge k+WAIT_CYCLES+1 (one per WAIT_CYCLES+1 cycles).
- A read issued after a write to the same index returns the new data; the two accesses are never concurrent.
- req_ready is combinational from state and reset. All other outputs are flops.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: a request with req_addr[1:0] ≠ 0 performs no array access. Its response has rsp_error = 1 and rsp_rdata = 0, with the same latency as a normal access.
- DMEM_MISALIGN_TRAP_EN not defined: req_addr[1:0] is ignored, the access proceeds on the word index, and rsp_error is constant 0.

## Test plan
- Write then read, WAIT_CYCLES = 2:
  - Write 0x0000_0010 ← 0xDEAD_BEEF accepted at edge 0 → rsp_valid high after edge 2 with rdata 0, req_ready high again after edge 3.
  - Read 0x10 → rsp_rdata = 0xDEAD_BEEF exactly 2 edges after its accept.
- WAIT_CYCLES = 0, back-to-back reads of 0x0 and 0x4 with req_valid held high → accepts on alternate edges, one rsp_valid pulse per request.
- Busy: req_valid pulsed with write 0x20 ← 0x1234 while in WAIT → no accept; mem[8] is unchanged on a later read.
- Aliasing, DEPTH = 256: write 0x0000_0404 ← 0xA5A5_A5A5, then read 0x0000_0004 → 0xA5A5_A5A5.
- Reset mid-operation:
  - Write to 0x8 ← 0xFFFF_FFFF accepted, reset asserted 1 cycle later → outputs 0 and req_ready 0 during reset, IDLE after release; a subsequent read of 0x8 returns its prior value (0).
- Misaligned 0x0000_0013:
  - With DMEM_MISALIGN_TRAP_EN: a write of 0x5555_5555 sets rsp_error = 1 and leaves mem[4] unchanged.
  - Without DMEM_MISALIGN_TRAP_EN: the same write lands in mem[4], rsp_error = 0.
